// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: 32-bit word stream in, 16-word padded blocks out.
// Appends the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        C,
    input  logic        R,
    input  logic [0:31] IN_WORD,
    input  logic        IN_VALID,
    input  logic        IN_LAST,
    input  logic [1:0]  IN_NBYTES,
    output logic        IN_READY,
    output logic [0:31] OUT_WORD,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_FIRST,
    output logic        OUT_LASTW,
    output logic        MSG_DONE
);

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD80,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    state_t             r_state;
    logic [3:0]         r_idx;
    logic [LEN_W-4:0]   r_bytes;
    logic [0:31]        r_word;
    logic               r_valid;
    logic               r_first;
    logic               r_lastw;
    logic               r_done;

    logic               w_free;
    logic               w_load;
    logic [3:0]         w_next_idx;
    logic [2:0]         w_n;
    logic [0:31]        w_mark;
    logic [LEN_W-1:0]   w_bitlen;
    logic [63:0]        w_len64;

    // r_idx is the block position of the next word to enter the output register
    assign w_free     = !r_valid || OUT_READY;
    assign IN_READY   = (r_state == S_DATA) && w_free;
    assign w_load     = w_free && ((r_state != S_DATA) || IN_VALID);
    assign w_next_idx = r_idx + 4'd1;
    assign w_n        = (IN_NBYTES == 2'd0) ? 3'd4 : {1'b0, IN_NBYTES};
    assign w_bitlen   = {r_bytes, 3'b000};
    assign w_len64    = 64'(w_bitlen);

    assign OUT_WORD   = r_word;
    assign OUT_VALID  = r_valid;
    assign OUT_FIRST  = r_first;
    assign OUT_LASTW  = r_lastw;
    assign MSG_DONE   = r_done;

    // Final partial word: keep the valid leading bytes, insert the marker
    always_comb begin
        w_mark = IN_WORD;
        case (IN_NBYTES)
            2'd1:    w_mark = {IN_WORD[0:7], 8'h80, 16'h0000};
            2'd2:    w_mark = {IN_WORD[0:15], 8'h80, 8'h00};
            2'd3:    w_mark = {IN_WORD[0:23], 8'h80};
            default: w_mark = IN_WORD;
        endcase
    end

    // Padding FSM with a single registered output stage
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= S_DATA;
            r_idx   <= 4'd0;
            r_bytes <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_lastw <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (r_valid && OUT_READY) begin
                r_valid <= 1'b0;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_first <= (r_idx == 4'd0);
                r_lastw <= (r_idx == 4'd15);
                r_done  <= (r_state == S_LEN_LO);
                r_idx   <= w_next_idx;
                case (r_state)
                    S_DATA: begin
                        if (IN_LAST) begin
                            r_bytes <= r_bytes + (LEN_W-3)'(w_n);
                            if (w_n == 3'd4) begin
                                r_word  <= IN_WORD;
                                r_state <= S_PAD80;
                            end else begin
                                r_word  <= w_mark;
                                r_state <= (w_next_idx == 4'd14) ?
                                           S_LEN_HI : S_ZERO;
                            end
                        end else begin
                            r_bytes <= r_bytes + (LEN_W-3)'(3'd4);
                            r_word  <= IN_WORD;
                        end
                    end
                    S_PAD80: begin
                        r_word  <= 32'h8000_0000;
                        r_state <= (w_next_idx == 4'd14) ?
                                   S_LEN_HI : S_ZERO;
                    end
                    S_ZERO: begin
                        r_word <= 32'h0000_0000;
                        if (w_next_idx == 4'd14) begin
                            r_state <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        r_word  <= w_len64[63:32];
                        r_state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        r_word  <= w_len64[31:0];
                        r_bytes <= '0;
                        r_state <= S_DATA;
                    end
                    default: begin
                        r_state <= S_DATA;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder.
// A byte-level padding model fills the expected queue; a monitor drains it.
module tb_sha256_msg_padder;

    logic        C = 1'b0;
    logic        R = 1'b0;
    logic [31:0] IN_WORD = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_LAST = 1'b0;
    logic [1:0]  IN_NBYTES = 2'd0;
    logic        IN_READY;
    logic [31:0] OUT_WORD;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        OUT_FIRST;
    logic        OUT_LASTW;
    logic        MSG_DONE;

    int checks = 0;
    int errors = 0;
    bit sb_on = 1'b1;
    bit bp_stop = 1'b0;

    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [31:0] w;
        logic        f;
        logic        l;
        logic        d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .C(C),
        .R(R),
        .IN_WORD(IN_WORD),
        .IN_VALID(IN_VALID),
        .IN_LAST(IN_LAST),
        .IN_NBYTES(IN_NBYTES),
        .IN_READY(IN_READY),
        .OUT_WORD(OUT_WORD),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_FIRST(OUT_FIRST),
        .OUT_LASTW(OUT_LASTW),
        .MSG_DONE(MSG_DONE)
    );

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_model(input wq_t w, input logic [1:0] nb);
        logic [7:0]  b[$];
        logic [31:0] x;
        logic [63:0] bits;
        exp_t        e;
        int          n;
        int          nw;
        for (int i = 0; i < w.size(); i++) begin
            x = w[i];
            n = 4;
            if (i == w.size() - 1 && nb != 2'd0) n = int'(nb);
            for (int k = 0; k < n; k++) b.push_back(x[31-8*k -: 8]);
        end
        bits = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int k = 0; k < 8; k++) b.push_back(bits[63-8*k -: 8]);
        nw = b.size() / 4;
        for (int i = 0; i < nw; i++) begin
            e.w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            e.f = ((i % 16) == 0);
            e.l = ((i % 16) == 15);
            e.d = (i == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input wq_t w, input logic [1:0] nb,
                        input bit last_on);
        bit acc;
        int t;
        for (int i = 0; i < w.size(); i++) begin
            IN_WORD   = w[i];
            IN_VALID  = 1'b1;
            IN_LAST   = last_on && (i == w.size() - 1);
            IN_NBYTES = IN_LAST ? nb : 2'd0;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 1000) begin
                @(negedge C);
                acc = IN_READY;
                @(posedge C);
                #1;
                t++;
            end
            chk("in_accept", {63'd0, acc}, 64'd1);
        end
        IN_VALID  = 1'b0;
        IN_LAST   = 1'b0;
        IN_NBYTES = 2'd0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge C);
            t++;
        end
        repeat (3) @(posedge C);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic msg(input wq_t w, input logic [1:0] nb);
        push_model(w, nb);
        send(w, nb, 1'b1);
    endtask

    always @(negedge C) begin
        if (sb_on && R && OUT_VALID && OUT_READY) begin
            chk("sb_has_exp", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("word", 64'(OUT_WORD), 64'(mon_e.w));
                chk("first", 64'(OUT_FIRST), 64'(mon_e.f));
                chk("lastw", 64'(OUT_LASTW), 64'(mon_e.l));
                chk("done", 64'(MSG_DONE), 64'(mon_e.d));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t         w;
        logic [31:0] held;
        logic [1:0]  nb;

        R = 1'b0;
        repeat (2) @(posedge C);
        #1;
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_word", 64'(OUT_WORD), 64'd0);
        chk("rst_first", 64'(OUT_FIRST), 64'd0);
        chk("rst_lastw", 64'(OUT_LASTW), 64'd0);
        chk("rst_done", 64'(MSG_DONE), 64'd0);
        chk("rst_inrdy", 64'(IN_READY), 64'd1);
        R = 1'b1;
        @(posedge C);
        #1;

        w = {32'h6162_6300};
        msg(w, 2'd3);
        drain();

        w = {32'h0000_0001, 32'h1234_5678, 32'hABCD_EF00, 32'hBAD0_E0F0,
             32'hFFFF_FFFF, 32'h0128_0256, 32'hAAAA_AAAA};
        msg(w, 2'd0);
        drain();

        w = {};
        for (int i = 0; i < 14; i++) w.push_back(32'h0101_0101 * (i + 1));
        msg(w, 2'd0);
        drain();

        w = {};
        for (int i = 0; i < 10; i++) w.push_back(32'hC000_0000 + i);
        push_model(w, 2'd2);
        fork
            send(w, 2'd2, 1'b1);
            begin
                repeat (5) @(posedge C);
                #1;
                OUT_READY = 1'b0;
                held = OUT_WORD;
                repeat (3) begin
                    @(negedge C);
                    chk("bp_valid", 64'(OUT_VALID), 64'd1);
                    chk("bp_word", 64'(OUT_WORD), 64'(held));
                    chk("bp_inrdy", 64'(IN_READY), 64'd0);
                    @(posedge C);
                end
                #1;
                OUT_READY = 1'b1;
            end
        join
        drain();

        sb_on = 1'b0;
        w = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
             32'h4444_4444, 32'h5555_5555};
        send(w, 2'd0, 1'b0);
        R = 1'b0;
        #1;
        chk("r5_valid", 64'(OUT_VALID), 64'd0);
        chk("r5_word", 64'(OUT_WORD), 64'd0);
        chk("r5_first", 64'(OUT_FIRST), 64'd0);
        chk("r5_done", 64'(MSG_DONE), 64'd0);
        @(posedge C);
        #1;
        R = 1'b1;
        sb_on = 1'b1;
        @(posedge C);
        #1;
        w = {32'h6162_6300};
        msg(w, 2'd3);
        drain();

        w = {32'h6162_6300};
        push_model(w, 2'd3);
        w = {32'hDEAD_BEEF};
        push_model(w, 2'd0);
        w = {32'h6162_6300};
        send(w, 2'd3, 1'b1);
        w = {32'hDEAD_BEEF};
        send(w, 2'd0, 1'b1);
        drain();

        fork
            begin
                for (int m = 0; m < 5; m++) begin
                    w = {};
                    for (int i = 0; i < int'($urandom_range(1, 20)); i++)
                        w.push_back($urandom);
                    nb = 2'($urandom_range(0, 3));
                    msg(w, nb);
                end
                drain();
                bp_stop = 1'b1;
            end
            begin
                while (!bp_stop) begin
                    @(posedge C);
                    #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        OUT_READY = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
